// File: rtl/acc_requant_if.sv
// Stream bundle for acc_requant: accumulator beats in, requantized activations out.
// The master side feeds beats and consumes results; the slave side is the requantizer.
interface acc_requant_if #(
  parameter int N       = 16,
  parameter int SHIFT_W = 6
);
  logic                  valid_i;
  logic                  ready_o;
  logic signed [2*N-1:0] acc_i;
  logic signed [2*N-1:0] bias_i;
  logic [SHIFT_W-1:0]    shift_i;
  logic                  relu_en_i;

  logic                  valid_o;
  logic                  ready_i;
  logic signed [N-1:0]   q_o;
  logic                  sat_o;

  modport master (
    output valid_i, acc_i, bias_i, shift_i, relu_en_i, ready_i,
    input  ready_o, valid_o, q_o, sat_o
  );

  modport slave (
    input  valid_i, acc_i, bias_i, shift_i, relu_en_i, ready_i,
    output ready_o, valid_o, q_o, sat_o
  );
endinterface

// File: rtl/acc_requant.sv
// Requantizer behind the mac accumulator: bias add, rounding shift, optional ReLU
// and saturation to N bits, as a 2-stage full-throughput valid/ready pipeline.
module acc_requant #(
  parameter int N       = 16,
  parameter int SHIFT_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  acc_requant_if.slave      bus,
  input  logic              clear_i,
  output logic [CNT_W-1:0]  sat_count_o
);

  localparam int AW   = 2 * N;
  localparam int SW   = 2 * N + 2;
  localparam int SH_W = $clog2(2 * N + 1);

  localparam logic signed [SW-1:0] QMax = (SW'(1) <<< (N - 1)) - SW'(1);
  localparam logic signed [SW-1:0] QMin = ~QMax;

  logic                 v1, v2;
  logic signed [SW-1:0] sum1;
  logic [SH_W-1:0]      sh1;
  logic                 relu1;

  logic                 accept, adv2, handoff;
  logic signed [SW-1:0] sum_in;
  logic [SH_W-1:0]      sh_in;

  logic signed [SW-1:0] half, rnd, r;
  logic signed [N-1:0]  q_nxt;
  logic                 sat_nxt;

  // A full pipe can still take a beat when the output drains this cycle.
  assign bus.ready_o = !v1 || !v2 || bus.ready_i;
  assign bus.valid_o = v2;
  assign accept      = bus.valid_i && bus.ready_o;
  assign adv2        = v1 && (!v2 || bus.ready_i);
  assign handoff     = v2 && bus.ready_i;

  assign sum_in = SW'(bus.acc_i) + SW'(bus.bias_i);

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    if (int'(bus.shift_i) > AW) sh_in = SH_W'(AW);
    else                        sh_in = SH_W'(bus.shift_i);
  end

  // Adding half an LSB before the arithmetic shift rounds half toward +inf;
  // with sh1 == 0 the half term collapses to zero and the sum passes through.
  always_comb begin
    half    = SW'(1) << sh1;
    half    = half >>> 1;
    rnd     = sum1 + half;
    r       = rnd >>> sh1;
    if (relu1 && r[SW-1]) r = '0;
    sat_nxt = 1'b0;
    q_nxt   = r[N-1:0];
    if (r > QMax) begin
      q_nxt   = QMax[N-1:0];
      sat_nxt = 1'b1;
    end else if (r < QMin) begin
      q_nxt   = QMin[N-1:0];
      sat_nxt = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the datapath registers are reset as well so q_o/sat_o read 0 during reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      sum1      <= '0;
      sh1       <= '0;
      relu1     <= 1'b0;
      bus.q_o   <= '0;
      bus.sat_o <= 1'b0;
    end else begin
      if (accept) begin
        v1    <= 1'b1;
        sum1  <= sum_in;
        sh1   <= sh_in;
        relu1 <= bus.relu_en_i;
      end else if (adv2) begin
        v1 <= 1'b0;
      end

      if (adv2) begin
        v2        <= 1'b1;
        bus.q_o   <= q_nxt;
        bus.sat_o <= sat_nxt;
      end else if (handoff) begin
        v2 <= 1'b0;
      end
    end
  end

  // Clear takes priority over a same-cycle clamped hand-off.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_count_o <= '0;
    end else if (clear_i) begin
      sat_count_o <= '0;
    end else if (handoff && bus.sat_o && (sat_count_o != '1)) begin
      sat_count_o <= sat_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_acc_requant.sv
// Randomized bench for acc_requant against an arithmetic reference model and
// an in-order scoreboard that also predicts valid/ready and the clamp counter.
module tb_acc_requant;

  localparam int N = 16;

  typedef struct {
    int q;
    bit sat;
    int edge_no;
  } beat_t;

  logic        clk_i;
  logic        rst_ni;
  logic        clear_i;
  logic [15:0] sat_count_o;

  acc_requant_if #(.N(N), .SHIFT_W(6)) bus ();

  acc_requant #(.N(N), .SHIFT_W(6), .CNT_W(16)) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .bus         (bus),
    .clear_i     (clear_i),
    .sat_count_o (sat_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int    n_chk = 0;
  int    n_err = 0;
  int    cyc   = 0;
  int    cnt_m = 0;
  beat_t sb[$];
  int    out_log[$];

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic on the sum, floor division by 2^sh after
  // adding half, then ReLU, then clamp to the signed N-bit range.
  function automatic beat_t ref_beat(input int acc, input int bias, input int shift,
                                     input bit relu);
    beat_t  b;
    longint sum, r;
    int     sh;
    sum = longint'(acc) + longint'(bias);
    sh  = (shift > 2 * N) ? 2 * N : shift;
    if (sh == 0) r = sum;
    else         r = (sum + (longint'(1) << (sh - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    b.sat = 1'b0;
    if (r > 32767) begin
      r     = 32767;
      b.sat = 1'b1;
    end else if (r < -32768) begin
      r     = -32768;
      b.sat = 1'b1;
    end
    b.q       = int'(r);
    b.edge_no = 0;
    return b;
  endfunction

  // One clock cycle: drive at negedge, compare against the model, then update
  // the model with what the edge does. A beat accepted at edge e is on the
  // output from edge e+1 on; capacity is two beats.
  task automatic step(input bit vin, input int acc, input int bias, input int shift,
                      input bit relu, input bit rdy, input bit clr, output bit took);
    bit    exp_valid, exp_ready, handoff, sat_e;
    beat_t b;
    @(negedge clk_i);
    bus.valid_i   = vin;
    bus.acc_i     = acc;
    bus.bias_i    = bias;
    bus.shift_i   = 6'(shift);
    bus.relu_en_i = relu;
    bus.ready_i   = rdy;
    clear_i       = clr;
    #1;
    exp_valid = (sb.size() > 0) && (cyc >= sb[0].edge_no + 1);
    exp_ready = !(sb.size() == 2 && !rdy);
    check("valid_o", bus.valid_o, exp_valid);
    check("ready_o", bus.ready_o, exp_ready);
    check("sat_count_o", sat_count_o, cnt_m);
    if (exp_valid) begin
      check("q_o", bus.q_o, sb[0].q);
      check("sat_o", bus.sat_o, sb[0].sat);
    end
    handoff = exp_valid && rdy;
    took    = vin && exp_ready;
    if (handoff) out_log.push_back(int'(bus.q_o));
    @(posedge clk_i);
    cyc++;
    sat_e = 1'b0;
    if (handoff) begin
      sat_e = sb[0].sat;
      void'(sb.pop_front());
    end
    if (took) begin
      b         = ref_beat(acc, bias, shift, relu);
      b.edge_no = cyc;
      sb.push_back(b);
    end
    if (clr) cnt_m = 0;
    else if (handoff && sat_e && cnt_m != 65535) cnt_m++;
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, t);
  endtask

  function automatic int rnd_val();
    int v;
    case ($urandom_range(0, 3))
      0:       v = int'($urandom);
      1:       v = int'($urandom_range(0, 140000)) - 70000;
      2:       v = ($urandom_range(0, 1) == 1) ? 32'sh7fff_ffff : 32'sh8000_0000;
      default: v = int'($urandom_range(0, 2000000)) - 1000000;
    endcase
    return v;
  endfunction

  initial begin
    bit t;
    int nxt;

    rst_ni        = 1'b0;
    clear_i       = 1'b0;
    bus.valid_i   = 1'b0;
    bus.acc_i     = '0;
    bus.bias_i    = '0;
    bus.shift_i   = '0;
    bus.relu_en_i = 1'b0;
    bus.ready_i   = 1'b0;
    #1;
    check("rst_valid_o", bus.valid_o, 0);
    check("rst_q_o", bus.q_o, 0);
    check("rst_sat_o", bus.sat_o, 0);
    check("rst_count", sat_count_o, 0);
    #11 rst_ni = 1'b1;

    // Basic, rounding and back-to-back beats.
    step(1'b1, 1000, 24, 3, 1'b0, 1'b1, 1'b0, t);
    step(1'b1, -5, 0, 1, 1'b0, 1'b1, 1'b0, t);
    step(1'b1, 5, 0, 1, 1'b0, 1'b1, 1'b0, t);
    step(1'b1, 2, 0, 0, 1'b0, 1'b1, 1'b0, t);
    idle(3);

    // Saturation both ways, then clear against a simultaneous clamped hand-off.
    step(1'b1, 32'h0010_0000, 0, 4, 1'b0, 1'b1, 1'b0, t);
    step(1'b1, -32'sh0010_0000, 0, 4, 1'b0, 1'b1, 1'b0, t);
    idle(3);
    #1 check("sat_count_two", sat_count_o, 2);
    step(1'b1, 32'h0010_0000, 0, 4, 1'b0, 1'b1, 1'b0, t);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, t);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1, t);
    #1 check("clear_wins", sat_count_o, 0);
    idle(1);

    // ReLU on and off, plus shift boundaries.
    step(1'b1, -100, 0, 0, 1'b1, 1'b1, 1'b0, t);
    step(1'b1, -100, 0, 0, 1'b0, 1'b1, 1'b0, t);
    step(1'b1, 32'sh8000_0000, 32'sh8000_0000, 40, 1'b0, 1'b1, 1'b0, t);
    step(1'b1, 32'sh7fff_ffff, 32'sh7fff_ffff, 63, 1'b0, 1'b1, 1'b0, t);
    step(1'b1, -3, 0, 33, 1'b0, 1'b1, 1'b0, t);
    idle(3);

    // Backpressure: five beats, ready_i low for three cycles after the first output.
    out_log.delete();
    nxt = 1;
    for (int k = 0; k < 40 && !(nxt > 5 && sb.size() == 0); k++) begin
      step(nxt <= 5, nxt, 0, 0, 1'b0, !(k >= 1 && k <= 3), 1'b0, t);
      if (t) nxt++;
    end
    check("bp_drained", sb.size(), 0);
    check("bp_count", out_log.size(), 5);
    for (int i = 0; i < 5 && i < out_log.size(); i++) check("bp_order", out_log[i], i + 1);

    // Reset mid-stream with two beats in flight and a non-zero counter.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0100_0000, 0, 2, 1'b0, 1'b1, 1'b0, t);
    idle(3);
    #1 check("pre_rst_count", sat_count_o, 3);
    step(1'b1, 11, 0, 0, 1'b0, 1'b0, 1'b0, t);
    step(1'b1, 22, 0, 0, 1'b0, 1'b0, 1'b0, t);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_valid_o", bus.valid_o, 0);
    check("mid_rst_count", sat_count_o, 0);
    check("mid_rst_q_o", bus.q_o, 0);
    bus.valid_i = 1'b0;
    sb.delete();
    cnt_m = 0;
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    idle(4);

    // Randomized traffic with random backpressure and occasional clears.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, rnd_val(), rnd_val(),
           ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 20)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, t);
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
    check("final_drained", sb.size(), 0);
    idle(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
